// File: rtl/code_length_checker.sv
// Counts key presses of lock/program code-entry sessions and reports whether each
// completed session had a legal length; aborts on comparator error, clear or inactivity.
module code_length_checker #(
    parameter int KEY_W       = 4,
    parameter int CNT_W       = 4,
    parameter int UC_MIN_LEN  = 3,
    parameter int UC_MAX_LEN  = 5,
    parameter int PC_LEN      = 5,
    parameter int PROG_ROUNDS = 3,
    parameter int LOCK_KEY    = 9,
    parameter int PROG_KEY    = 8,
    parameter int CLEAR_KEY   = 7,
    parameter int TIMEOUT_CYC = 1000,
    localparam int RI_W       = (PROG_ROUNDS < 2) ? 1 : $clog2(PROG_ROUNDS + 1)
) (
    input  logic             hwclk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key,
    input  logic             input_wrong,
    output logic             valid_uc,
    output logic             valid_pc,
    output logic             done,
    output logic             timeout,
    output logic             busy,
    output logic             mode_prog,
    output logic [CNT_W-1:0] digit_cnt,
    output logic [RI_W-1:0]  round_idx
);

    localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_LOCK, S_PROG} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RI_W-1:0]  rnd_q, rnd_d;
    logic [TO_W-1:0]  idle_q, idle_d;
    logic             ovf_q, ovf_d;
    logic             ok_q, ok_d;
    logic             vuc_q, vuc_d;
    logic             vpc_q, vpc_d;
    logic             done_q, done_d;
    logic             to_q, to_d;
    logic             busy_q, mp_q;

    logic is_lock, is_prog, is_clear, is_digit, expire, abort, round_ok, uc_legal;

    assign is_lock  = (key == KEY_W'(LOCK_KEY));
    assign is_prog  = (key == KEY_W'(PROG_KEY));
    assign is_clear = (key == KEY_W'(CLEAR_KEY));
    assign is_digit = !(is_lock || is_prog || is_clear);
    assign expire   = (TIMEOUT_CYC != 0) && (state_q != S_IDLE) && (idle_q == TO_LAST);
    assign round_ok = (int'(cnt_q) == PC_LEN) && !ovf_q;
    assign uc_legal = !ovf_q && (int'(cnt_q) >= UC_MIN_LEN) && (int'(cnt_q) <= UC_MAX_LEN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        ovf_d   = ovf_q;
        ok_d    = ok_q;
        vuc_d   = vuc_q;
        vpc_d   = vpc_q;
        done_d  = 1'b0;
        to_d    = 1'b0;
        abort   = 1'b0;
        idle_d  = (state_q == S_IDLE) ? '0 : idle_q + TO_W'(1);

        if (input_wrong) begin
            abort = 1'b1;
        end else if (expire) begin
            abort = 1'b1;
            to_d  = 1'b1;
        end else if (key_valid) begin
            idle_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (is_lock || is_prog) begin
                        state_d = is_lock ? S_LOCK : S_PROG;
                        cnt_d   = '0;
                        rnd_d   = '0;
                        ovf_d   = 1'b0;
                        ok_d    = 1'b1;
                        vuc_d   = 1'b0;
                        vpc_d   = 1'b0;
                    end
                end
                S_LOCK: begin
                    if (is_clear) begin
                        abort = 1'b1;
                    end else if (is_lock) begin
                        state_d = S_IDLE;
                        vuc_d   = uc_legal;
                        done_d  = 1'b1;
                    end else if (is_digit) begin
                        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                        else                  cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PROG: begin
                    if (is_clear) begin
                        abort = 1'b1;
                    end else if (is_prog) begin
                        ok_d  = ok_q && round_ok;
                        cnt_d = '0;
                        // The last round closes the session and reports the AND of all rounds.
                        if (int'(rnd_q) == PROG_ROUNDS - 1) begin
                            state_d = S_IDLE;
                            vpc_d   = ok_q && round_ok;
                            done_d  = 1'b1;
                            rnd_d   = '0;
                        end else begin
                            rnd_d = rnd_q + RI_W'(1);
                        end
                    end else if (is_digit) begin
                        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                        else                  cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: abort = 1'b1;
            endcase
        end

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rnd_d   = '0;
            ovf_d   = 1'b0;
            vuc_d   = 1'b0;
            vpc_d   = 1'b0;
            idle_d  = '0;
        end
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rnd_q   <= '0;
            idle_q  <= '0;
            ovf_q   <= 1'b0;
            ok_q    <= 1'b0;
            vuc_q   <= 1'b0;
            vpc_q   <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
            mp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            idle_q  <= idle_d;
            ovf_q   <= ovf_d;
            ok_q    <= ok_d;
            vuc_q   <= vuc_d;
            vpc_q   <= vpc_d;
            done_q  <= done_d;
            to_q    <= to_d;
            busy_q  <= (state_d != S_IDLE);
            mp_q    <= (state_d == S_PROG);
        end
    end

    assign valid_uc  = vuc_q;
    assign valid_pc  = vpc_q;
    assign done      = done_q;
    assign timeout   = to_q;
    assign busy      = busy_q;
    assign mode_prog = mp_q;
    assign digit_cnt = cnt_q;
    assign round_idx = rnd_q;

endmodule

// File: tb/tb_code_length_checker.sv
// Randomized and directed bench for code_length_checker; two instances (CNT_W 4 and 3)
// share the stimulus and are compared every cycle against a session-level model.
`timescale 1ns/1ps
module tb_code_length_checker;

    logic       hwclk = 1'b0;
    logic       reset;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic       input_wrong = 1'b0;

    logic       vuc0, vpc0, done0, to0, busy0, mp0;
    logic [3:0] dc0;
    logic [1:0] ri0;
    logic       vuc1, vpc1, done1, to1, busy1, mp1;
    logic [2:0] dc1;
    logic [1:0] ri1;

    always #5 hwclk = ~hwclk;

    code_length_checker u_dut0 (
        .hwclk(hwclk), .reset(reset), .key_valid(key_valid), .key(key),
        .input_wrong(input_wrong), .valid_uc(vuc0), .valid_pc(vpc0), .done(done0),
        .timeout(to0), .busy(busy0), .mode_prog(mp0), .digit_cnt(dc0), .round_idx(ri0)
    );

    code_length_checker #(.CNT_W(3), .TIMEOUT_CYC(20)) u_dut1 (
        .hwclk(hwclk), .reset(reset), .key_valid(key_valid), .key(key),
        .input_wrong(input_wrong), .valid_uc(vuc1), .valid_pc(vpc1), .done(done1),
        .timeout(to1), .busy(busy1), .mode_prog(mp1), .digit_cnt(dc1), .round_idx(ri1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Session-level model: mode 0=idle 1=lock 2=prog; raw digit count is unbounded.
    int CMAX[2] = '{15, 7};
    int TOUT[2] = '{1000, 20};
    int m_mode[2], m_digits[2], m_rounds[2], m_last[2];
    bit m_vuc[2], m_vpc[2], m_ok[2], m_done[2], m_to[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset(input int m);
        m_mode[m] = 0; m_digits[m] = 0; m_rounds[m] = 0; m_last[m] = cyc;
        m_vuc[m] = 0; m_vpc[m] = 0; m_ok[m] = 0; m_done[m] = 0; m_to[m] = 0;
    endfunction

    function automatic void model_abort(input int m);
        m_mode[m] = 0; m_digits[m] = 0; m_rounds[m] = 0; m_vuc[m] = 0; m_vpc[m] = 0;
    endfunction

    function automatic void model_step(input int m, input bit kv, input int k, input bit iw);
        m_done[m] = 0;
        m_to[m]   = 0;
        if (iw) begin
            model_abort(m);
        end else if (m_mode[m] != 0 && TOUT[m] != 0 && cyc - m_last[m] == TOUT[m]) begin
            model_abort(m);
            m_to[m] = 1;
        end else if (kv) begin
            m_last[m] = cyc;
            if (m_mode[m] == 0) begin
                if (k == 9 || k == 8) begin
                    m_mode[m] = (k == 9) ? 1 : 2;
                    m_digits[m] = 0; m_rounds[m] = 0; m_ok[m] = 1;
                    m_vuc[m] = 0; m_vpc[m] = 0;
                end
            end else if (k == 7) begin
                model_abort(m);
            end else if (m_mode[m] == 1 && k == 9) begin
                m_vuc[m]  = (m_digits[m] <= CMAX[m]) && (m_digits[m] >= 3) && (m_digits[m] <= 5);
                m_done[m] = 1;
                m_mode[m] = 0;
            end else if (m_mode[m] == 2 && k == 8) begin
                m_ok[m] = m_ok[m] && (m_digits[m] == 5);
                m_digits[m] = 0;
                m_rounds[m]++;
                if (m_rounds[m] == 3) begin
                    m_vpc[m] = m_ok[m]; m_done[m] = 1; m_mode[m] = 0; m_rounds[m] = 0;
                end
            end else if (k != 8 && k != 9) begin
                m_digits[m]++;
            end
        end
    endfunction

    function automatic int shown_cnt(input int m);
        return (m_digits[m] > CMAX[m]) ? CMAX[m] : m_digits[m];
    endfunction

    task automatic compare_all();
        check("d0 valid_uc",  32'(vuc0),  32'(m_vuc[0]));
        check("d0 valid_pc",  32'(vpc0),  32'(m_vpc[0]));
        check("d0 done",      32'(done0), 32'(m_done[0]));
        check("d0 timeout",   32'(to0),   32'(m_to[0]));
        check("d0 busy",      32'(busy0), 32'(m_mode[0] != 0));
        check("d0 mode_prog", 32'(mp0),   32'(m_mode[0] == 2));
        check("d0 digit_cnt", 32'(dc0),   32'(shown_cnt(0)));
        check("d0 round_idx", 32'(ri0),   32'(m_rounds[0]));
        check("d1 valid_uc",  32'(vuc1),  32'(m_vuc[1]));
        check("d1 valid_pc",  32'(vpc1),  32'(m_vpc[1]));
        check("d1 done",      32'(done1), 32'(m_done[1]));
        check("d1 timeout",   32'(to1),   32'(m_to[1]));
        check("d1 busy",      32'(busy1), 32'(m_mode[1] != 0));
        check("d1 mode_prog", 32'(mp1),   32'(m_mode[1] == 2));
        check("d1 digit_cnt", 32'(dc1),   32'(shown_cnt(1)));
        check("d1 round_idx", 32'(ri1),   32'(m_rounds[1]));
    endtask

    task automatic tick(input bit kv, input int k, input bit iw);
        key_valid   = kv;
        key         = 4'(k);
        input_wrong = iw;
        @(posedge hwclk);
        cyc++;
        for (int m = 0; m < 2; m++) begin
            if (reset) model_reset(m);
            else       model_step(m, kv, k, iw);
        end
        #1;
        compare_all();
        key_valid   = 1'b0;
        input_wrong = 1'b0;
    endtask

    function automatic int rand_digit();
        int d;
        d = $urandom_range(0, 12);
        return (d < 7) ? d : d + 3;
    endfunction

    task automatic press(input int k);
        int gap;
        gap = ($urandom_range(0, 49) == 0) ? 22 : $urandom_range(0, 2);
        repeat (gap) tick(0, 0, 0);
        tick(1, k, $urandom_range(0, 199) == 0);
    endtask

    initial begin
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) model_reset(m);
        compare_all();
        tick(1, 9, 0);
        #2 reset = 1'b0;

        // Legal lock code of four digits
        tick(1, 9, 0);
        for (int i = 1; i <= 4; i++) tick(1, i, 0);
        check("uc4 digit_cnt", 32'(dc0), 32'd4);
        tick(1, 9, 0);
        check("uc4 done", 32'(done0), 32'd1);
        check("uc4 valid_uc", 32'(vuc0), 32'd1);
        tick(0, 0, 0);
        check("uc4 done pulse", 32'(done0), 32'd0);
        check("uc4 hold", 32'(vuc0), 32'd1);
        tick(1, 3, 0);
        tick(1, 7, 0);
        check("idle keys keep valid_uc", 32'(vuc0), 32'd1);

        // Too short and too long lock codes
        tick(1, 9, 0); tick(1, 1, 0); tick(1, 2, 0); tick(1, 9, 0);
        check("uc2 done", 32'(done0), 32'd1);
        check("uc2 valid_uc", 32'(vuc0), 32'd0);
        tick(1, 9, 0);
        repeat (6) tick(1, 5, 0);
        tick(1, 9, 0);
        check("uc6 valid_uc", 32'(vuc0), 32'd0);

        // Saturation on the narrow counter
        tick(1, 9, 0);
        repeat (9) tick(1, 1, 0);
        check("sat cnt_w3", 32'(dc1), 32'd7);
        check("sat cnt_w4", 32'(dc0), 32'd9);
        tick(1, 9, 0);
        check("sat valid_uc", 32'(vuc1), 32'd0);

        // Three legal program rounds, then one short round
        tick(1, 8, 0);
        for (int r = 0; r < 3; r++) begin
            repeat (5) tick(1, rand_digit(), 0);
            tick(1, 8, 0);
            check("pc round_idx", 32'(ri0), 32'((r + 1) % 3));
        end
        check("pc done", 32'(done0), 32'd1);
        check("pc valid_pc", 32'(vpc0), 32'd1);
        tick(1, 8, 0);
        repeat (4) tick(1, 2, 0);
        tick(1, 9, 0);
        tick(1, 8, 0);
        for (int r = 0; r < 2; r++) begin
            repeat (5) tick(1, 2, 0);
            tick(1, 8, 0);
        end
        check("pc short done", 32'(done0), 32'd1);
        check("pc short valid_pc", 32'(vpc0), 32'd0);

        // Clear key and comparator abort with a simultaneous LOCK_KEY
        tick(1, 8, 0); tick(1, 1, 0); tick(1, 7, 0);
        check("clear busy", 32'(busy0), 32'd0);
        check("clear done", 32'(done0), 32'd0);
        tick(1, 9, 0); tick(1, 1, 0); tick(1, 2, 0);
        tick(1, 9, 1);
        check("iw busy", 32'(busy0), 32'd0);
        check("iw done", 32'(done0), 32'd0);
        check("iw valid_uc", 32'(vuc0), 32'd0);

        // Timeout wins over a key on the expiring edge (short-timeout instance)
        tick(1, 9, 0);
        repeat (19) tick(0, 0, 0);
        tick(1, 9, 0);
        check("to prio timeout", 32'(to1), 32'd1);
        check("to prio done", 32'(done1), 32'd0);

        // Full-length inactivity timeout
        tick(1, 9, 0); tick(1, 1, 0);
        repeat (999) tick(0, 0, 0);
        check("to999 busy", 32'(busy0), 32'd1);
        check("to999 timeout", 32'(to0), 32'd0);
        tick(0, 0, 0);
        check("to1000 timeout", 32'(to0), 32'd1);
        check("to1000 busy", 32'(busy0), 32'd0);
        tick(0, 0, 0);
        check("to pulse", 32'(to0), 32'd0);

        // Asynchronous reset in the middle of a program session
        tick(1, 8, 0); tick(1, 1, 0); tick(1, 2, 0);
        #2 reset = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) model_reset(m);
        check("rst busy", 32'(busy0), 32'd0);
        check("rst mode_prog", 32'(mp0), 32'd0);
        check("rst digit_cnt", 32'(dc0), 32'd0);
        compare_all();
        tick(1, 9, 0);
        tick(1, 8, 0);
        #2 reset = 1'b0;
        repeat (3) tick(0, 0, 0);

        // Randomized sessions
        for (int s = 0; s < 80; s++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                press(9);
                len = $urandom_range(1, 9);
                repeat (len) press(rand_digit());
                press(($urandom_range(0, 9) == 0) ? 7 : 9);
            end else if (kind == 1) begin
                press(8);
                for (int r = 0; r < 3; r++) begin
                    len = ($urandom_range(0, 2) == 0) ? $urandom_range(3, 9) : 5;
                    repeat (len) press(($urandom_range(0, 14) == 0) ? 9 : rand_digit());
                    press(8);
                end
            end else begin
                for (int i = 0; i < 40; i++) begin
                    int r;
                    int k;
                    r = $urandom_range(0, 19);
                    k = (r < 2) ? 9 : (r < 4) ? 8 : (r == 4) ? 7 : rand_digit();
                    tick($urandom_range(0, 99) < 45, k, $urandom_range(0, 63) == 0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
